// File: rtl/chandrakanth_full_adder_pkg.sv
// Shared constants and result bundle for the 4-bit adder tile.
// Field positions of uo_out and uio_in, plus the registered result layout.
package chandrakanth_full_adder_pkg;

  localparam int WIDTH = 4;

  localparam int SUM_LSB   = 0;
  localparam int COUT_BIT  = 4;
  localparam int OVF_BIT   = 5;
  localparam int ZERO_BIT  = 6;
  localparam int VALID_BIT = 7;

  localparam int CIN_BIT  = 0;
  localparam int MODE_BIT = 1;

  typedef struct packed {
    logic             zero;
    logic             ovf;
    logic             cout;
    logic [WIDTH-1:0] sum;
  } res_t;

endpackage

// File: rtl/chandrakanth_full_adder_bit.sv
// One-bit full-adder cell used in the ripple-carry chain.
// Ports: a, b, ci -> s (sum), co (carry out).
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/chandrakanth_full_adder.sv
// Tiny Tapeout tile: 4-bit ripple-carry adder, combinational or registered.
// Ports: clk, rst_n (active-high async), ena, ui_in {B,A}, uio_in {mode,cin}, uo_out flags.
module chandrakanth_full_adder
  import chandrakanth_full_adder_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;
  logic             mode;

  res_t comb_res;
  res_t res_q;
  res_t sel_res;
  logic valid_q;
  logic sel_valid;

  logic unused_ok;

  assign a        = ui_in[WIDTH-1:0];
  assign b        = ui_in[2*WIDTH-1:WIDTH];
  assign carry[0] = uio_in[CIN_BIT];
  assign mode     = uio_in[MODE_BIT];

  assign unused_ok = &{1'b0, uio_in[7:2]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder_bit u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  // Signed overflow only possible when both operands share a sign.
  always_comb begin
    comb_res      = '0;
    comb_res.sum  = sum;
    comb_res.cout = carry[WIDTH];
    comb_res.ovf  = (a[WIDTH-1] == b[WIDTH-1])
                 && (sum[WIDTH-1] != a[WIDTH-1]);
    comb_res.zero = (sum == '0);
  end

  // Register keeps capturing regardless of mode.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      res_q   <= '0;
      valid_q <= 1'b0;
    end else if (ena) begin
      res_q   <= comb_res;
      valid_q <= 1'b1;
    end
  end

  always_comb begin
    sel_res   = comb_res;
    sel_valid = 1'b1;
    if (mode) begin
      sel_res   = res_q;
      sel_valid = valid_q;
    end
  end

  always_comb begin
    uo_out                    = '0;
    uo_out[SUM_LSB +: WIDTH]  = sel_res.sum;
    uo_out[COUT_BIT]          = sel_res.cout;
    uo_out[OVF_BIT]           = sel_res.ovf;
    uo_out[ZERO_BIT]          = sel_res.zero;
    uo_out[VALID_BIT]         = sel_valid;
  end

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_chandrakanth_full_adder.sv
// Self-checking bench for chandrakanth_full_adder.
// Arithmetic reference model plus directed literal checks.
module tb_chandrakanth_full_adder;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] ta, tb;
  logic       tcin, tmode;
  logic [6:0] m_reg;
  logic       m_valid;
  logic       mon_en;

  chandrakanth_full_adder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unused uio_in bits carry junk to show they are ignored.
  always_comb begin
    ui_in  = {tb, ta};
    uio_in = {6'b101101, tmode, tcin};
  end

  function automatic logic [6:0] pred(
    input int a, input int b, input int c);
    int s, sa, sb, ss;
    logic [6:0] r;
    s  = a + b + c;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    ss = sa + sb + c;
    r[3:0] = 4'(s % 16);
    r[4]   = (s > 15);
    r[5]   = (ss > 7) || (ss < -8);
    r[6]   = ((s % 16) == 0);
    return r;
  endfunction

  function automatic logic [7:0] exp_out();
    if (tmode)
      return {m_valid, m_reg};
    return {1'b1, pred(int'(ta), int'(tb), int'(tcin))};
  endfunction

  task automatic chk(input string name,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_model(input string name);
    chk(name, uo_out, exp_out());
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n && ena) begin
      m_reg   = pred(int'(ta), int'(tb), int'(tcin));
      m_valid = 1'b1;
    end
    #1;
  endtask

  task automatic set_in(input logic [3:0] a, input logic [3:0] b,
                        input logic c);
    ta   = a;
    tb   = b;
    tcin = c;
  endtask

  always @(negedge clk) begin
    if (mon_en) chk_model("monitor");
  end

  initial begin
    mon_en  = 1'b0;
    m_reg   = '0;
    m_valid = 1'b0;
    rst_n   = 1'b1;
    ena     = 1'b0;
    tmode   = 1'b1;
    set_in(4'h3, 4'h4, 1'b0);
    #1;
    chk("reset_uo", uo_out, 8'h00);
    chk("reset_oe", uio_oe, 8'h00);
    chk("reset_uio_out", uio_out, 8'h00);
    mon_en = 1'b1;

    ena = 1'b1;
    tick();
    tick();
    chk("reset_hold", uo_out, 8'h00);
    rst_n = 1'b0;
    #1;
    chk("release_no_clk", uo_out, 8'h00);
    tick();
    chk("first_capture", uo_out, 8'h87);

    tmode = 1'b0;
    set_in(4'h3, 4'h4, 1'b0);
    #1;
    chk("comb_3_4", {3'b000, uo_out[4:0]}, 8'h07);
    set_in(4'hF, 4'hF, 1'b1);
    #1;
    chk("comb_f_f_1", uo_out, 8'h9F);
    set_in(4'h8, 4'h8, 1'b0);
    #1;
    chk("comb_8_8", uo_out, 8'hF0);
    set_in(4'h7, 4'h1, 1'b0);
    #1;
    chk("comb_7_1", uo_out, 8'hA8);
    chk_model("comb_7_1_model");

    tick();
    tmode = 1'b1;
    set_in(4'h5, 4'h6, 1'b1);
    tick();
    chk("reg_5_6_1", {3'b000, uo_out[4:0]}, 8'h0C);
    chk("reg_5_6_1_full", uo_out, 8'hAC);
    set_in(4'h1, 4'h1, 1'b0);
    #1;
    chk("reg_hold_no_clk", uo_out, 8'hAC);

    ena = 1'b0;
    set_in(4'h2, 4'h9, 1'b0);
    tick();
    tick();
    tick();
    chk("ena0_hold", uo_out, 8'hAC);
    ena = 1'b1;
    tick();
    chk("ena1_capture", uo_out, 8'h8B);

    #2;
    rst_n   = 1'b1;
    m_reg   = '0;
    m_valid = 1'b0;
    #1;
    chk("midrun_reset", uo_out, 8'h00);
    tmode = 1'b0;
    #1;
    chk("reset_comb", uo_out, 8'h8B);
    tick();
    rst_n = 1'b0;
    tmode = 1'b1;
    tick();
    chk_model("after_reset_capture");

    tmode = 1'b0;
    for (int i = 0; i < 512; i++) begin
      tick();
      set_in(4'(i & 15), 4'((i >> 4) & 15), 1'((i >> 8) & 1));
      #1;
      chk_model("exhaustive");
    end

    tmode = 1'b1;
    tick();
    tick();
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
